// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bin_to_bcd_seq                                               |
// | Description : Sequential binary-to-packed-BCD converter using              |
// |               shift-and-add-3, one operand bit per clock.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 27,
  parameter int DIGITS    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  function automatic logic [63:0] f_pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam int          c_cnt_w   = $clog2(BIN_WIDTH + 1);
  localparam int          c_cat_w   = 4 * DIGITS + BIN_WIDTH;
  localparam logic [63:0] c_max_val = f_pow10(DIGITS) - 64'd1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BIN_WIDTH-1:0] r_bin_sh;
  logic [4*DIGITS-1:0]  r_scratch;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_ovf_int;
  logic                 r_busy;
  logic                 r_done;
  logic [4*DIGITS-1:0]  r_bcd;
  logic                 r_overflow;

  logic [4*DIGITS-1:0]  w_adj;
  logic [c_cat_w-1:0]   w_cat;
  logic [63:0]          w_bin_ext;

  // Add-3 correction per digit; digits never carry into each other.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                             (r_scratch[4*g +: 4] + 4'd3) : r_scratch[4*g +: 4];
  end

  assign w_cat     = {w_adj, r_bin_sh} << 1;
  assign w_bin_ext = 64'(bin);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == c_last_cnt) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin_sh   <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_int  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin_sh  <= bin;
            r_scratch <= '0;
            r_ovf_int <= (w_bin_ext > c_max_val);
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_scratch <= w_cat[c_cat_w-1:BIN_WIDTH];
          r_bin_sh  <= w_cat[BIN_WIDTH-1:0];
          r_cnt     <= r_cnt + c_cnt_w'(1);
        end
        S_DONE: begin
          // Out-of-range operands saturate to all nines for the display.
          r_bcd      <= r_ovf_int ? {DIGITS{4'h9}} : r_scratch;
          r_overflow <= r_ovf_int;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd      = r_bcd;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bin_to_bcd_seq                                            |
// | Description : Scoreboard bench for the sequential binary-to-BCD converter. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bin_to_bcd_seq;

  localparam int BIN_WIDTH = 27;
  localparam int DIGITS    = 8;
  localparam int LATENCY   = 28;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 start;
  logic [BIN_WIDTH-1:0] bin;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd;
  logic                 overflow;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          start_cyc = 0;
  logic [31:0] last_bcd = '0;
  logic        last_ovf = 1'b0;

  bin_to_bcd_seq #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Monitor: pops the scoreboard on every done pulse, and otherwise checks the result holds.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_bcd = '0;
      last_ovf = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("bcd", 64'(bcd), 64'(mon_e.bcd));
        chk("overflow", 64'(overflow), 64'(mon_e.ovf));
      end
      last_bcd = bcd;
      last_ovf = overflow;
    end else begin
      chk("bcd_hold", 64'(bcd), 64'(last_bcd));
      chk("ovf_hold", 64'(overflow), 64'(last_ovf));
    end
  end

  task automatic accept();
    @(posedge clk);
    #1;
    start_cyc = cyc;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic issue(input logic [BIN_WIDTH-1:0] v, input logic [31:0] eb, input logic eo);
    exp_t e;
    e.bcd = eb;
    e.ovf = eo;
    sb.push_back(e);
    bin   = v;
    start = 1'b1;
    accept();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit chk_busy);
    int n      = 0;
    int busy_n = 1;
    bit got    = 1'b0;
    while (n < 60 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done) got = 1'b1;
      else if (busy) busy_n++;
    end
    if (!got) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      chk("latency", 64'(cyc - start_cyc), 64'(LATENCY));
      chk("busy_low_at_done", 64'(busy), 64'd0);
      if (chk_busy) chk("busy_cycles", 64'(busy_n), 64'(LATENCY));
    end
  endtask

  task automatic done_width();
    @(posedge clk);
    #1;
    chk("done_width", 64'(done), 64'd0);
  endtask

  task automatic expect_quiet(input int n);
    int dn = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done) dn++;
    end
    chk("no_extra_done", 64'(dn), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    bin     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero operand
    issue(27'd0, 32'h00000000, 1'b0);
    wait_done(1'b1);
    done_width();

    // Mid-range value, busy and done pulse width
    issue(27'd12345678, 32'h12345678, 1'b0);
    wait_done(1'b1);
    done_width();

    // Largest representable value, then first out-of-range value
    issue(27'd99999999, 32'h99999999, 1'b0);
    wait_done(1'b1);
    done_width();
    issue(27'd100000000, 32'h99999999, 1'b1);
    wait_done(1'b1);
    done_width();

    // A start during a conversion is ignored
    issue(27'd42, 32'h00000042, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    bin   = 27'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignored_start", 64'(busy), 64'd1);
    wait_done(1'b0);
    expect_quiet(35);

    // Asynchronous reset in the middle of a conversion
    issue(27'd55555, 32'h00055555, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_bcd", 64'(bcd), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    expect_quiet(35);
    issue(27'd9, 32'h00000009, 1'b0);
    wait_done(1'b1);
    done_width();

    // Start held high: back-to-back conversions of 0..20
    begin
      exp_t e;
      e.bcd = to_bcd(0);
      e.ovf = 1'b0;
      sb.push_back(e);
      bin   = '0;
      start = 1'b1;
      accept();
      for (int k = 0; k <= 20; k++) begin
        wait_done(1'b1);
        if (k < 20) begin
          bin   = BIN_WIDTH'(k + 1);
          e.bcd = to_bcd(k + 1);
          e.ovf = 1'b0;
          sb.push_back(e);
          accept();
          chk("b2b_done_width", 64'(done), 64'd0);
        end else begin
          start = 1'b0;
          done_width();
        end
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
